// File: rtl/decoder_pkg.sv
// Shared constants and the combinational decode used by the registered decoder.
package decoder_pkg;

    localparam int IN_W_DEFAULT = 2;
    localparam int MAX_IN_W     = 6;
    localparam int MAX_OUT_W    = 64;

    function automatic int out_w(input int in_w);
        return 1 << in_w;
    endfunction

    // Widest-case one-hot; callers truncate to their own output width.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_IN_W-1:0] a,
                                                    input logic en);
        logic [MAX_OUT_W-1:0] r;
        r = '0;
        if (en) begin
            r[a] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder_2to4.sv
// Registered binary-to-one-hot decoder with enable and optional one-cold output.
module decoder_2to4
    import decoder_pkg::*;
#(
    parameter int IN_W           = IN_W_DEFAULT,
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IN_W-1:0]           A,
    input  logic                      E,
    output logic [out_w(IN_W)-1:0]    Y
);

    localparam int OUT_W = out_w(IN_W);

    if (IN_W < 1 || IN_W > MAX_IN_W) begin : g_bad_in_w
        $error("decoder_2to4: IN_W must be in 1..6");
    end

    logic [MAX_IN_W-1:0] a_ext;
    logic [OUT_W-1:0]    y_d;
    logic [OUT_W-1:0]    y_q;

    // Polarity is folded in before the register so Y is driven straight from a flop.
    always_comb begin
        a_ext            = '0;
        a_ext[IN_W-1:0]  = A;
        y_d              = OUT_W'(onehot(a_ext, E)) ^ {OUT_W{OUT_ACTIVE_LOW}};
    end

    // Reset value equals the disabled output for either polarity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= {OUT_W{OUT_ACTIVE_LOW}};
        end else begin
            y_q <= y_d;
        end
    end

    assign Y = y_q;

endmodule

// File: tb/tb_decoder_2to4.sv
// Bench for decoder_2to4: both output polarities driven by shared inputs.
module tb_decoder_2to4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] A;
    logic       E;
    logic [3:0] Y_hi;
    logic [3:0] Y_lo;

    int errors = 0;
    int checks = 0;

    decoder_2to4 #(.IN_W(2), .OUT_ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .A(A), .E(E), .Y(Y_hi)
    );

    decoder_2to4 #(.IN_W(2), .OUT_ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .A(A), .E(E), .Y(Y_lo)
    );

    always #5 clk = ~clk;

    // Reference: enabled -> bit number a set (2**a), disabled -> nothing set.
    function automatic logic [3:0] ref_y(input int a, input bit e);
        int v;
        v = e ? (2 ** a) : 0;
        return v[3:0];
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_both(input string tag, input logic [3:0] exp_hi);
        check({tag, "_hi"}, Y_hi, exp_hi);
        check({tag, "_lo"}, Y_lo, ~exp_hi);
        check({tag, "_onehot"}, {3'b000, ($countones(Y_hi) <= 1)}, 4'b0001);
        check({tag, "_onecold"}, {3'b000, ($countones(~Y_lo) <= 1)}, 4'b0001);
    endtask

    task automatic apply(input string tag, input int a, input bit e);
        @(negedge clk);
        A = 2'(a);
        E = e;
        @(posedge clk);
        #1;
        check_both(tag, ref_y(a, e));
    endtask

    initial begin
        rst = 1'b0;
        A   = 2'b00;
        E   = 1'b0;

        // Reset asserted asynchronously with an active decode request present.
        @(negedge clk);
        A   = 2'b11;
        E   = 1'b1;
        rst = 1'b1;
        #1;
        check_both("reset_immediate", 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        check_both("reset_hold", 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        apply("disabled_a0", 0, 1'b0);
        apply("disabled_a3", 3, 1'b0);

        for (int a = 0; a < 4; a++) begin
            apply($sformatf("sweep_a%0d", a), a, 1'b1);
        end

        apply("repeat_a3", 3, 1'b1);
        apply("jump_a1", 1, 1'b1);
        apply("jump_a3", 3, 1'b1);

        // Reset pulse between edges drops the decode without a clock edge.
        apply("midrst_pre", 2, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_both("midrst_async", 4'b0000);
        #2;
        rst = 1'b0;
        #1;
        check_both("midrst_released", 4'b0000);
        @(posedge clk);
        #1;
        check_both("midrst_recapture", ref_y(2, 1'b1));

        apply("etoggle_off", 2, 1'b0);
        apply("etoggle_a_change", 1, 1'b0);

        for (int i = 0; i < 60; i++) begin
            apply($sformatf("rand_%0d", i), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decoder_2to4.md
# decoder_2to4

Registered binary-to-one-hot decoder with enable. Converts an IN_W-bit select code into a 2**IN_W-bit one-hot word when enabled; drives all-zeros when disabled. Used as the select/strobe generator in front of small register banks and output muxes. Output is registered on one clock for glitch-free downstream enables.

## Interface
- IN_W, 2, width of select input A; output width is 2**IN_W (default 4).
- OUT_ACTIVE_LOW, 0, when 1 the registered output is inverted (one-cold, idle all-ones).
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high; one clock domain (clk) only.
- A  input  IN_W  binary select code, A[IN_W-1] is MSB.
- E  input  1  decode enable, active-high.
- Y  output  2**IN_W  decoded one-hot output, registered.

## Operation
- Decode rule (OUT_ACTIVE_LOW=0): E=1 -> Y[i]=1 exactly for i==A, all other bits 0; E=0 -> Y all 0.
- Default widths: A=00->0001, 01->0010, 10->0100, 11->1000; E=0 -> 0000 regardless of A.
- OUT_ACTIVE_LOW=1: Y is bitwise inverse of the above (E=0 -> all 1s; A=01,E=1 -> 1101).
- At most one asserted bit on Y at any time (one-hot or zero); never multi-hot.
- A and E unknown/X handling is not required; inputs are assumed driven by synchronous logic in clk domain.
- No other state; Y is a pure registered function of previous-cycle A and E.
- IN_W range: 1..6 (output up to 64 bits); elaboration error outside this range.

## Timing
- Latency 1 cycle: A/E sampled at rising clk edge n, Y reflects them after edge n, stable until edge n+1.
- Reset value: Y = all 0 (OUT_ACTIVE_LOW=0) or all 1 (OUT_ACTIVE_LOW=1), i.e. the disabled state.
- rst assertion forces reset value immediately, independent of clk; held while rst=1.
- rst deassertion: first capture on first rising clk edge with rst=0.
- Reset mid-operation: active decode dropped instantly; no residual one-hot after rst released until a new sampled E=1.
- Simultaneous A and E change in same cycle: Y reflects the new pair after next edge, with no intermediate value.
- E toggled 1->0: Y goes to disabled value after the next edge; A changes while E=0 have no visible effect.

## Structure
- Shared package decoder_pkg: IN_W default constant, function out_w(in_w) returning 2**in_w, and the combinational decode function onehot(a, en).
- Single module, no sub-modules; combinational decode feeding one output register with async reset.
- Optional polarity inversion applied before the register so the register holds final output polarity.

## Test plan
- Reset: assert rst with A=11,E=1 -> Y=0000 immediately; hold for 2 cycles -> Y stays 0000.
- Disabled: rst=0, E=0, A=00 then 11 -> Y=0000 after each edge.
- Enabled sweep: E=1, A=00,01,10,11 on consecutive cycles -> Y=0001,0010,0100,1000, each one cycle after its input.
- Same-code repeat and jump: E=1 A=11, then A=01, then A=11 -> Y=1000,0010,1000; check exactly one bit high every cycle.
- Reset mid-operation: E=1 A=10 (Y=0100), pulse rst between edges -> Y=0000 without clock edge; after release, next edge -> Y=0100.
- Polarity: OUT_ACTIVE_LOW=1, E=0 -> Y=1111; E=1 A=01 -> Y=1101; rst -> Y=1111.
